// File: rtl/alu_op_sequencer.sv
// Sequences one SPARC V8 integer op at a time through an external combinational ALU, committing icc/Y and reporting traps.
// Optional macro ALU_OP_SEQUENCER_DIV0_TRAP_EN: trap divide-by-zero in EXEC instead of running the full divide.
module alu_op_sequencer #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [5:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [31:0] alu_yin,
   output logic        alu_cin,
   input  logic [31:0] alu_res,
   input  logic [31:0] alu_yout,
   input  logic        alu_n,
   input  logic        alu_z,
   input  logic        alu_v,
   input  logic        alu_c,
   input  logic        alu_trap,
   output logic        resp_valid,
   output logic [31:0] resp_result,
   output logic        resp_wr,
   output logic        resp_trap,
   output logic [1:0]  resp_trap_type,
   output logic        icc_n,
   output logic        icc_z,
   output logic        icc_v,
   output logic        icc_c,
   output logic [31:0] y_reg
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam int CW = 16;

   logic [1:0]    r_state;
   logic [5:0]    r_op;
   logic [31:0]   r_a;
   logic [31:0]   r_b;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_result;
   logic [31:0]   r_y;
   logic          r_wr;
   logic [1:0]    r_trap_type;
   logic [3:0]    r_icc;

   logic w_illegal;
   logic w_mul;
   logic w_div;
   logic w_div0;
   logic w_tv;
   logic w_cc;
   logic w_mul_wait;
   logic w_div_wait;
   logic w_capture;

   assign w_illegal  = (r_op > 6'd39);
   assign w_mul      = !r_op[5] && (r_op[3:1] == 3'b101);
   assign w_div      = !r_op[5] && (r_op[3:1] == 3'b111);
   assign w_tv       = (r_op == 6'd34) || (r_op == 6'd35);
   assign w_cc       = (r_op >= 6'd16) && (r_op <= 6'd36);
   assign w_mul_wait = w_mul && (MUL_CYCLES > 1);
   assign w_div_wait = w_div && (DIV_CYCLES > 1);

`ifdef ALU_OP_SEQUENCER_DIV0_TRAP_EN
   assign w_div0 = w_div && (r_b == 32'd0);
`else
   assign w_div0 = 1'b0;
`endif

   // Result is sampled on the edge that leaves EXEC (single-cycle) or the last WAIT cycle.
   assign w_capture = ((r_state == S_EXEC) && !w_illegal && !w_div0 && !w_mul_wait && !w_div_wait)
                   || ((r_state == S_WAIT) && (r_cnt == '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_y         <= '0;
         r_wr        <= 1'b0;
         r_trap_type <= 2'd0;
         r_icc       <= 4'b0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_op    <= req_op;
                  r_a     <= req_a;
                  r_b     <= req_b;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (w_illegal) begin
                  r_trap_type <= 2'd3;
                  r_wr        <= 1'b0;
                  r_state     <= S_DONE;
               end else if (w_div0) begin
                  r_trap_type <= 2'd2;
                  r_wr        <= 1'b0;
                  r_state     <= S_DONE;
               end else if (w_mul_wait) begin
                  r_cnt   <= CW'(MUL_CYCLES - 2);
                  r_state <= S_WAIT;
               end else if (w_div_wait) begin
                  r_cnt   <= CW'(DIV_CYCLES - 2);
                  r_state <= S_WAIT;
               end else begin
                  r_state <= S_DONE;
               end
            end
            S_WAIT: begin
               if (r_cnt == '0) r_state <= S_DONE;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_capture) begin
            r_result <= alu_res;
            if (w_tv && alu_trap) begin
               r_trap_type <= 2'd1;
               r_wr        <= 1'b0;
            end else begin
               r_trap_type <= 2'd0;
               r_wr        <= 1'b1;
               if (w_cc)  r_icc <= {alu_n, alu_z, alu_v, alu_c};
               if (w_mul) r_y   <= alu_yout;
            end
         end
      end
   end

   assign req_ready      = (r_state == S_IDLE);
   assign resp_valid     = (r_state == S_DONE);
   assign resp_result    = r_result;
   assign resp_wr        = r_wr;
   assign resp_trap      = (r_trap_type != 2'd0);
   assign resp_trap_type = r_trap_type;
   assign {icc_n, icc_z, icc_v, icc_c} = r_icc;
   assign y_reg          = r_y;
   assign alu_op         = r_op;
   assign alu_a          = r_a;
   assign alu_b          = r_b;
   assign alu_yin        = r_y;
   assign alu_cin        = r_icc[0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU attached to the alu_* ports.
module tb_alu_op_sequencer;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_op;
   logic [31:0] req_a, req_b;
   logic [5:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_yin;
   logic        alu_cin;
   logic [31:0] alu_res, alu_yout;
   logic        alu_n, alu_z, alu_v, alu_c, alu_trap;
   logic        resp_valid, resp_wr, resp_trap;
   logic [31:0] resp_result;
   logic [1:0]  resp_trap_type;
   logic        icc_n, icc_z, icc_v, icc_c;
   logic [31:0] y_reg;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_yin(alu_yin), .alu_cin(alu_cin),
      .alu_res(alu_res), .alu_yout(alu_yout), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
      .alu_c(alu_c), .alu_trap(alu_trap),
      .resp_valid(resp_valid), .resp_result(resp_result), .resp_wr(resp_wr),
      .resp_trap(resp_trap), .resp_trap_type(resp_trap_type),
      .icc_n(icc_n), .icc_z(icc_z), .icc_v(icc_v), .icc_c(icc_c), .y_reg(y_reg)
   );

   // Reference ALU: only the opcodes exercised below are modelled
   logic [32:0] sum33;
   logic [63:0] prod;
   logic [63:0] quot;
   always_comb begin
      alu_res  = '0;
      alu_yout = '0;
      alu_v    = 1'b0;
      alu_c    = 1'b0;
      alu_trap = 1'b0;
      prod     = '0;
      quot     = '0;
      sum33 = {1'b0, alu_a} + {1'b0, alu_b}
            + {32'd0, ((alu_op == 6'd8) || (alu_op == 6'd24)) ? alu_cin : 1'b0};
      case (alu_op)
         6'd0, 6'd8, 6'd16, 6'd24, 6'd34: begin
            alu_res = sum33[31:0];
            alu_c   = sum33[32];
            alu_v   = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
            if (alu_op == 6'd34) begin
               alu_v    = alu_v | (|(alu_a[1:0] | alu_b[1:0]));
               alu_trap = alu_v;
            end
         end
         6'd10: begin
            prod = {32'd0, alu_a} * {32'd0, alu_b};
            alu_res = prod[31:0]; alu_yout = prod[63:32];
         end
         6'd11: begin
            prod = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
            alu_res = prod[31:0]; alu_yout = prod[63:32];
         end
         6'd14: begin
            if (alu_b == 32'd0) alu_res = 32'hFFFF_FFFF;
            else begin
               quot = {alu_yin, alu_a} / {32'd0, alu_b};
               alu_res = quot[31:0];
            end
         end
         default: alu_res = alu_a & alu_b;
      endcase
      alu_n = alu_res[31];
      alu_z = (alu_res == 32'd0);
   end

   // Issue one request; lat counts edges from the accept edge to the first resp_valid cycle.
   task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int ready_hi);
      @(negedge clk);
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; ready_hi = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (resp_valid) break;
         if (req_ready) ready_hi++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", req_ready); end
      n_cmp++; if ({resp_valid, resp_wr, resp_trap, resp_trap_type} !== 5'b0) begin n_err++;
         $display("FAIL reset_resp got %b%b%b%0d want 0000", resp_valid, resp_wr, resp_trap, resp_trap_type); end
      n_cmp++; if ({resp_result, y_reg} !== 64'd0) begin n_err++; $display("FAIL reset_regs got %h/%h want 0/0", resp_result, y_reg); end
      n_cmp++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b0000) begin n_err++; $display("FAIL reset_icc got %b want 0000", {icc_n, icc_z, icc_v, icc_c}); end
      n_cmp++; if ({alu_op, alu_a, alu_b} !== 70'd0) begin n_err++; $display("FAIL reset_alu got %0d %h %h want 0", alu_op, alu_a, alu_b); end
      reset = 1'b0;
   endtask

   task automatic test_addcc;
      int lat, rh;
      do_op(6'd16, 32'hFFFF_FFFF, 32'd1, lat, rh);
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL addcc_lat got %0d want 2", lat); end
      n_cmp++; if (resp_result !== 32'd0) begin n_err++; $display("FAIL addcc_res got %h want 0", resp_result); end
      n_cmp++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b0101) begin n_err++; $display("FAIL addcc_icc got %b want 0101", {icc_n, icc_z, icc_v, icc_c}); end
      n_cmp++; if ({resp_wr, resp_trap_type} !== 3'b100) begin n_err++; $display("FAIL addcc_wr got %b/%0d want 1/0", resp_wr, resp_trap_type); end
   endtask

   task automatic test_addx;
      int lat, rh;
      do_op(6'd8, 32'd1, 32'd1, lat, rh);
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL addx_lat got %0d want 2", lat); end
      n_cmp++; if (resp_result !== 32'd3) begin n_err++; $display("FAIL addx_res got %h want 3", resp_result); end
      n_cmp++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b0101) begin n_err++; $display("FAIL addx_icc got %b want 0101", {icc_n, icc_z, icc_v, icc_c}); end
   endtask

   task automatic test_umul;
      int lat, rh;
      do_op(6'd10, 32'h0001_0000, 32'h0001_0000, lat, rh);
      n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL umul_lat got %0d want 5", lat); end
      n_cmp++; if (rh !== 0) begin n_err++; $display("FAIL umul_ready_low got %0d high cycles want 0", rh); end
      n_cmp++; if (resp_result !== 32'd0) begin n_err++; $display("FAIL umul_res got %h want 0", resp_result); end
      n_cmp++; if (y_reg !== 32'd1) begin n_err++; $display("FAIL umul_y got %h want 1", y_reg); end
      n_cmp++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b0101) begin n_err++; $display("FAIL umul_icc got %b want 0101", {icc_n, icc_z, icc_v, icc_c}); end
   endtask

   task automatic test_udiv;
      int lat, rh;
      do_op(6'd14, 32'd0, 32'd2, lat, rh);
      n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL udiv_lat got %0d want 9", lat); end
      n_cmp++; if (resp_result !== 32'h8000_0000) begin n_err++; $display("FAIL udiv_res got %h want 80000000", resp_result); end
      n_cmp++; if (y_reg !== 32'd1) begin n_err++; $display("FAIL udiv_y got %h want 1", y_reg); end
   endtask

   task automatic test_div0;
      int lat, rh;
      do_op(6'd14, 32'd5, 32'd0, lat, rh);
`ifdef ALU_OP_SEQUENCER_DIV0_TRAP_EN
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL div0_lat got %0d want 2", lat); end
      n_cmp++; if ({resp_wr, resp_trap, resp_trap_type} !== 4'b0110) begin n_err++;
         $display("FAIL div0_trap got wr%b trap%b type%0d want wr0 trap1 type2", resp_wr, resp_trap, resp_trap_type); end
`else
      n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL div0_lat got %0d want 9", lat); end
      n_cmp++; if ({resp_wr, resp_trap, resp_trap_type} !== 4'b1000) begin n_err++;
         $display("FAIL div0_trap got wr%b trap%b type%0d want wr1 trap0 type0", resp_wr, resp_trap, resp_trap_type); end
      n_cmp++; if (resp_result !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_res got %h want ffffffff", resp_result); end
`endif
      n_cmp++; if ({y_reg, icc_n, icc_z, icc_v, icc_c} !== {32'd1, 4'b0101}) begin n_err++;
         $display("FAIL div0_state got y=%h icc=%b want y=1 icc=0101", y_reg, {icc_n, icc_z, icc_v, icc_c}); end
   endtask

   task automatic test_traps;
      int lat, rh;
      do_op(6'd34, 32'd1, 32'd4, lat, rh);
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL tv_lat got %0d want 2", lat); end
      n_cmp++; if ({resp_wr, resp_trap, resp_trap_type} !== 4'b0101) begin n_err++;
         $display("FAIL tv_trap got wr%b trap%b type%0d want wr0 trap1 type1", resp_wr, resp_trap, resp_trap_type); end
      n_cmp++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b0101) begin n_err++; $display("FAIL tv_icc got %b want 0101", {icc_n, icc_z, icc_v, icc_c}); end
      do_op(6'd40, 32'd7, 32'd9, lat, rh);
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL illegal_lat got %0d want 2", lat); end
      n_cmp++; if ({resp_wr, resp_trap, resp_trap_type} !== 4'b0111) begin n_err++;
         $display("FAIL illegal_trap got wr%b trap%b type%0d want wr0 trap1 type3", resp_wr, resp_trap, resp_trap_type); end
   endtask

   // ADDcc sets C, a following ADDX held on req_valid must see that carry.
   task automatic test_back_to_back;
      int first, second, drop;
      logic [31:0] r1, r2;
      first = 0; second = 0; drop = 0; r1 = '0; r2 = '0;
      @(negedge clk);
      req_op = 6'd16; req_a = 32'hFFFF_FFFF; req_b = 32'd2; req_valid = 1'b1;
      @(posedge clk);
      #1 req_op = 6'd8; req_a = 32'd0; req_b = 32'd0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (drop != 0) req_valid = 1'b0;
         if (resp_valid) begin
            if (first == 0) begin first = k; r1 = resp_result; end
            else begin second = k; r2 = resp_result; break; end
         end
         if (first != 0 && req_ready) drop = 1;
      end
      req_valid = 1'b0;
      n_cmp++; if (first !== 2 || second !== 5) begin n_err++; $display("FAIL b2b_timing got %0d,%0d want 2,5", first, second); end
      n_cmp++; if (r1 !== 32'd1 || r2 !== 32'd1) begin n_err++; $display("FAIL b2b_res got %h,%h want 1,1", r1, r2); end
      n_cmp++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b0001) begin n_err++; $display("FAIL b2b_icc got %b want 0001", {icc_n, icc_z, icc_v, icc_c}); end
   endtask

   task automatic test_reset_mid;
      int seen;
      seen = 0;
      @(negedge clk);
      req_op = 6'd11; req_a = 32'hFFFF_FFFE; req_b = 32'd3; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) begin @(negedge clk); if (resp_valid) seen++; end
      reset = 1'b1;
      @(negedge clk);
      if (resp_valid) seen++;
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", req_ready); end
      n_cmp++; if ({y_reg, icc_n, icc_z, icc_v, icc_c} !== 36'd0) begin n_err++;
         $display("FAIL rstmid_state got y=%h icc=%b want 0/0000", y_reg, {icc_n, icc_z, icc_v, icc_c}); end
      reset = 1'b0;
      repeat (10) begin @(negedge clk); if (resp_valid) seen++; end
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_resp got %0d pulses want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_addcc();
      test_addx();
      test_umul();
      test_udiv();
      test_div0();
      test_traps();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
